// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: funct codes,
// FSM state encoding and the divide-by-zero result policy.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Division by zero: LO is filled with this bit, HI returns the dividend.
  localparam logic DIV0_LO_FILL     = 1'b1;
  localparam logic DIV0_HI_DIVIDEND = 1'b1;

  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return f[1];
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return ~f[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the issue stage and the mult/div unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  // start is a single-cycle request: it is taken only when the unit is idle
  // (busy low) and flush is low; otherwise it is dropped, never queued.
  // funct/a/b need only be valid in the cycle start is taken.
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;
  state_t           state;

  modport master (
    output start, funct, a, b, flush,
    input  busy, done, hi, lo, rdata, state
  );

  modport slave (
    input  start, funct, a, b, flush,
    output busy, done, hi, lo, rdata, state
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on a
// {hi,lo} accumulator pair; purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, hi_in} + {1'b0, opnd};
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    hi_out  = hi_in;
    lo_out  = lo_in;
    if (is_div) begin
      // Remainder stays below the divisor, so a clear top bit means no borrow.
      if (!diff[WIDTH]) begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = shifted[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_in[0]) begin
        {hi_out, lo_out} = {sum, lo_in[WIDTH-1:1]};
      end else begin
        {hi_out, lo_out} = {1'b0, hi_in, lo_in[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: WIDTH-cycle iterative mult/div on
// operand magnitudes with a sign fixup on the final step, plus mthi/mtlo.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, a_hold_q;
  logic             div_q, neg_q_q, neg_r_q, b_zero_q, done_q;

  logic             accept, fin, op_md, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo, fix_hi, fix_lo;
  logic [WIDTH-1:0] q_s, r_s;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    accept    = (state_q == ST_IDLE) && bus.start && !bus.flush;
    op_md     = is_muldiv(bus.funct);
    op_signed = is_signed_op(bus.funct);
    a_neg     = op_signed & bus.a[WIDTH-1];
    b_neg     = op_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    fin       = (state_q == ST_BUSY) && !bus.flush && (cnt_q == '0);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .hi_in  (acc_hi_q),
    .lo_in  (acc_lo_q),
    .opnd   (opnd_q),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Sign fixup is applied to the last step's output in the same cycle.
  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_q_q ? -prod : prod;
    q_s    = neg_q_q ? -step_lo : step_lo;
    r_s    = neg_r_q ? -step_hi : step_hi;
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    if (div_q) begin
      if (b_zero_q) begin
        fix_lo = {WIDTH{DIV0_LO_FILL}};
        fix_hi = DIV0_HI_DIVIDEND ? a_hold_q : '0;
      end else begin
        fix_lo = q_s;
        fix_hi = r_s;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && op_md) state_d = ST_BUSY;
      ST_BUSY: if (bus.flush || cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      a_hold_q <= '0;
      div_q    <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= fin;
      case (state_q)
        ST_IDLE: begin
          if (accept && op_md) begin
            cnt_q    <= CW'(WIDTH - 1);
            div_q    <= is_div_op(bus.funct);
            acc_hi_q <= '0;
            acc_lo_q <= is_div_op(bus.funct) ? a_mag : b_mag;
            opnd_q   <= is_div_op(bus.funct) ? b_mag : a_mag;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= is_div_op(bus.funct) & a_neg;
            b_zero_q <= (bus.b == '0);
            a_hold_q <= bus.a;
          end else if (accept && bus.funct == FN_MTHI) begin
            hi_q <= bus.a;
          end else if (accept && bus.funct == FN_MTLO) begin
            lo_q <= bus.a;
          end
        end
        ST_BUSY: begin
          if (bus.flush) begin
            cnt_q <= '0;
          end else begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            if (cnt_q == '0) begin
              hi_q <= fix_hi;
              lo_q <= fix_lo;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign bus.busy  = (state_q == ST_BUSY);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state_q;
  assign bus.rdata = (bus.funct == FN_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an arithmetic
// reference model of the HI/LO results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus32 ();
  muldiv_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(bus8));

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi32, cur_lo32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: full-precision integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [5:0] f, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] hi, output logic [63:0] lo);
    longint unsigned mask, ua, ub;
    longint sa, sb, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    if (f[0] == 1'b0) begin
      sa = longint'(ua << (64 - w)) >>> (64 - w);
      sb = longint'(ub << (64 - w)) >>> (64 - w);
    end else begin
      sa = longint'(ua);
      sb = longint'(ub);
    end
    if (f[1] == 1'b0) begin
      p  = sa * sb;
      lo = 64'(p) & mask;
      hi = (64'(p) >> w) & mask;
    end else if (ub == 0) begin
      lo = mask;
      hi = ua;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = 64'(q) & mask;
      hi = 64'(r) & mask;
    end
  endfunction

  task automatic go32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] h, l;
    bus32.start = 1'b1;
    bus32.funct = f;
    bus32.a     = a;
    bus32.b     = b;
    if (is_muldiv(f)) begin
      model(32, f, 64'(a), 64'(b), h, l);
      exp_q.push_back({h[31:0], l[31:0]});
    end else if (f == FN_MTHI) cur_hi32 = a;
    else if (f == FN_MTLO) cur_lo32 = a;
  endtask

  task automatic finish32(input string tag);
    int n;
    logic [63:0] e;
    @(negedge clk);
    bus32.start = 1'b0;
    bus32.a     = $urandom;
    bus32.b     = $urandom;
    bus32.funct = 6'($urandom_range(0, 63));
    n = 0;
    while (bus32.busy && n < 100) begin
      n++;
      if (n == 2) chk({tag, "_hold"}, {bus32.hi, bus32.lo}, {cur_hi32, cur_lo32});
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
    chk({tag, "_done"}, 64'(bus32.done), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk({tag, "_hi"}, 64'(bus32.hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(bus32.lo), 64'(e[31:0]));
    cur_hi32 = e[63:32];
    cur_lo32 = e[31:0];
  endtask

  task automatic mt32(input string tag, input logic [5:0] f, input logic [31:0] a);
    @(negedge clk);
    go32(f, a, 32'h0);
    @(negedge clk);
    bus32.start = 1'b0;
    chk({tag, "_hi"}, 64'(bus32.hi), 64'(cur_hi32));
    chk({tag, "_lo"}, 64'(bus32.lo), 64'(cur_lo32));
    chk({tag, "_busy"}, 64'(bus32.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus32.done), 64'd0);
  endtask

  task automatic run8(input string tag, input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
    int n;
    logic [63:0] h, l;
    model(8, f, 64'(a), 64'(b), h, l);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.funct = f;
    bus8.a     = a;
    bus8.b     = b;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    n = 0;
    while (bus8.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd8);
    chk({tag, "_done"}, 64'(bus8.done), 64'd1);
    chk({tag, "_hi"}, 64'(bus8.hi), h);
    chk({tag, "_lo"}, 64'(bus8.lo), l);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus32.start = 1'b0; bus32.funct = 6'h0; bus32.a = '0; bus32.b = '0; bus32.flush = 1'b0;
    bus8.start  = 1'b0; bus8.funct  = 6'h0; bus8.a  = '0; bus8.b  = '0; bus8.flush  = 1'b0;
    cur_hi32 = '0;
    cur_lo32 = '0;

    // Reset state, plus a start held while reset is high must be ignored.
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 64'(bus32.busy), 64'd0);
    chk("rst_done", 64'(bus32.done), 64'd0);
    chk("rst_hi", 64'(bus32.hi), 64'd0);
    chk("rst_lo", 64'(bus32.lo), 64'd0);
    chk("rst8_hilo", 64'({bus8.hi, bus8.lo}), 64'd0);
    bus32.start = 1'b1; bus32.funct = FN_MTHI; bus32.a = 32'hAAAA;
    @(negedge clk);
    chk("rst_start_ignored", 64'(bus32.hi), 64'd0);
    reset = 1'b0;
    bus32.start = 1'b0;

    // Directed arithmetic cases with literal expectations.
    @(negedge clk);
    go32(FN_MULT, 32'hFFFFFFFF, 32'd2);
    finish32("mult");
    chk("mult_hi_const", 64'(bus32.hi), 64'hFFFFFFFF);
    chk("mult_lo_const", 64'(bus32.lo), 64'hFFFFFFFE);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus32.done), 64'd0);
    go32(FN_MULTU, 32'hFFFFFFFF, 32'd2);
    finish32("multu");
    chk("multu_hi_const", 64'(bus32.hi), 64'h00000001);
    chk("multu_lo_const", 64'(bus32.lo), 64'hFFFFFFFE);
    @(negedge clk);
    go32(FN_DIV, 32'hFFFFFFF9, 32'd2);
    finish32("div_neg7");
    chk("div_neg7_lo_const", 64'(bus32.lo), 64'hFFFFFFFD);
    chk("div_neg7_hi_const", 64'(bus32.hi), 64'hFFFFFFFF);
    @(negedge clk);
    go32(FN_DIVU, 32'd7, 32'd0);
    finish32("divu_zero");
    chk("divu_zero_lo_const", 64'(bus32.lo), 64'hFFFFFFFF);
    chk("divu_zero_hi_const", 64'(bus32.hi), 64'h00000007);
    @(negedge clk);
    go32(FN_DIV, 32'h80000000, 32'hFFFFFFFF);
    finish32("div_ovf");
    chk("div_ovf_lo_const", 64'(bus32.lo), 64'h80000000);
    chk("div_ovf_hi_const", 64'(bus32.hi), 64'h0);
    bus32.funct = FN_MFHI;
    #1 chk("rdata_mfhi", 64'(bus32.rdata), 64'(cur_hi32));
    bus32.funct = FN_MFLO;
    #1 chk("rdata_mflo", 64'(bus32.rdata), 64'(cur_lo32));

    // Flush mid-multiply; a start during busy must be dropped.
    mt32("mthi", FN_MTHI, 32'h1234);
    mt32("mtlo", FN_MTLO, 32'h55);
    @(negedge clk);
    bus32.start = 1'b1; bus32.funct = FN_MULT; bus32.a = $urandom; bus32.b = $urandom;
    @(negedge clk);
    bus32.start = 1'b0;
    chk("flush_busy_c1", 64'(bus32.busy), 64'd1);
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      bus32.start = (c == 5);
      if (c == 5) begin
        bus32.funct = FN_MTLO;
        bus32.a = 32'hDEAD;
      end
    end
    bus32.flush = 1'b1;
    @(negedge clk);
    bus32.flush = 1'b0;
    chk("flush_busy", 64'(bus32.busy), 64'd0);
    chk("flush_done", 64'(bus32.done), 64'd0);
    chk("flush_hi", 64'(bus32.hi), 64'h1234);
    chk("flush_lo", 64'(bus32.lo), 64'h55);
    @(negedge clk);
    chk("flush_done_after", 64'(bus32.done), 64'd0);

    // Flush in IDLE outranks a simultaneous start.
    bus32.flush = 1'b1; bus32.start = 1'b1; bus32.funct = FN_MTHI; bus32.a = 32'hBEEF;
    @(negedge clk);
    bus32.flush = 1'b0; bus32.start = 1'b0;
    chk("idle_flush_hi", 64'(bus32.hi), 64'h1234);
    chk("idle_flush_busy", 64'(bus32.busy), 64'd0);

    // Back-to-back: next start driven in the done cycle.
    @(negedge clk);
    go32(FN_MULTU, $urandom, $urandom);
    finish32("b2b_first");
    go32(FN_DIVU, $urandom, $urandom | 32'h1);
    finish32("b2b_second");

    for (int i = 0; i < 16; i++) begin
      logic [5:0]  f;
      logic [31:0] ra, rb;
      case ($urandom_range(0, 5))
        0: f = FN_MULT;
        1: f = FN_MULTU;
        2: f = FN_DIV;
        3: f = FN_DIVU;
        4: f = FN_MTHI;
        default: f = FN_MTLO;
      endcase
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if (is_muldiv(f)) begin
        @(negedge clk);
        go32(f, ra, rb);
        finish32("rand_md");
      end else begin
        mt32("rand_mt", f, ra);
      end
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus32.start = 1'b1; bus32.funct = FN_DIV; bus32.a = 32'd100; bus32.b = 32'd7;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus32.busy), 64'd0);
    chk("midrst_done", 64'(bus32.done), 64'd0);
    chk("midrst_hi", 64'(bus32.hi), 64'd0);
    chk("midrst_lo", 64'(bus32.lo), 64'd0);
    chk("midrst_state", 64'(bus32.state), 64'(ST_IDLE));
    cur_hi32 = '0;
    cur_lo32 = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    go32(FN_MULT, $urandom, $urandom);
    finish32("post_rst");

    // Narrow instance.
    run8("w8_multu", FN_MULTU, 8'hFF, 8'hFF);
    chk("w8_hi_const", 64'(bus8.hi), 64'hFE);
    chk("w8_lo_const", 64'(bus8.lo), 64'h01);
    run8("w8_div", FN_DIV, 8'h80, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      logic [5:0] f;
      f = {4'b0110, 2'($urandom_range(0, 3))};
      run8("w8_rand", f, 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even numbers 8..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request valid for funct/a/b this cycle.
REQ-005 SHALL have port funct  input  6  MIPS R-type Funct field selecting the operation.
REQ-006 SHALL have port a  input  WIDTH  rs operand (dividend/multiplicand/mthi-mtlo source).
REQ-007 SHALL have port b  input  WIDTH  rt operand (divisor/multiplier).
REQ-008 SHALL have port flush  input  1  abort any in-flight mult/div.
REQ-009 SHALL have port busy  output  1  iterative op in progress; upstream stalls.
REQ-010 SHALL have port done  output  1  one-cycle pulse: HI/LO just updated by mult/div.
REQ-011 SHALL have port hi  output  WIDTH  HI register.
REQ-012 SHALL have port lo  output  WIDTH  LO register.
REQ-013 SHALL have port rdata  output  WIDTH  combinational: hi when funct=mfhi, else lo.

Function
REQ-014 SHALL decode funct: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo, 010000 mfhi, 010010 mflo.
REQ-015 SHALL treat an op as signed iff funct[0]=0 (mult, div); unsigned otherwise.
REQ-016 SHALL accept start only in IDLE; start while busy, or with any other funct, SHALL cause no state change.
REQ-017 SHALL, on accepted mthi/mtlo, write a into HI/LO at that edge; busy and done stay 0.
REQ-018 SHALL treat mfhi/mflo as state-free reads via rdata.
REQ-019 SHALL implement FSM IDLE -> BUSY on accepted mult/div; counter loaded WIDTH-1.
REQ-020 SHALL, in BUSY, perform one shift-add (mult) or restoring-subtract (div) step per cycle on operand magnitudes; counter decrements.
REQ-021 SHALL, in BUSY with counter=0, at the next edge apply sign fixup, write HI/LO, return to IDLE and assert done for exactly the following cycle.
REQ-022 SHALL hold busy high exactly WIDTH cycles, starting the cycle after the accepting edge; done SHALL be high in the first cycle busy is low.
REQ-023 SHALL hold HI/LO unchanged during BUSY; a/b/funct SHALL need to be valid only in the accepting cycle.
REQ-024 SHALL produce mult as the full 2*WIDTH product, HI = upper half, LO = lower half.
REQ-025 SHALL produce div as LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-026 SHALL, for b=0 (div/divu), give LO = all ones, HI = a; no exception.
REQ-027 SHALL, for signed div of -2^(WIDTH-1) by -1, give LO = -2^(WIDTH-1), HI = 0.
REQ-028 SHALL, on flush in BUSY, return to IDLE at that edge with HI/LO unchanged and no done; flush in IDLE is a no-op; flush outranks a simultaneous start.
REQ-029 SHALL accept a new start in the same cycle done is high.

Reset
REQ-030 SHALL, on reset assertion, immediately force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, independent of clk, including mid-operation.
REQ-031 SHALL ignore start on the first edge after reset deassertion only if reset is still high at that edge.

Structure
REQ-032 SHALL place funct codes, FSM state encoding and DIV0 result policy constants in shared package muldiv_pkg.
REQ-033 SHALL isolate the per-cycle shift-add / restoring-subtract step in sub-module muldiv_step (parameter WIDTH); FSM, counter, sign fixup and HI/LO in muldiv_unit.

Verification
REQ-034 SHALL check (WIDTH=32) mult a=0xFFFFFFFF b=2 -> busy 32 cycles, done next cycle, HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-035 SHALL check div a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=7 b=0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-036 SHALL check div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 SHALL check mthi 0x1234 then mult with flush at busy cycle 10 -> busy falls next cycle, no done, HI=0x1234; start during busy ignored.
REQ-038 SHALL check reset asserted mid-div -> busy, done, hi, lo all 0 before next clk edge; back-to-back start on done cycle accepted.
REQ-039 SHALL check WIDTH=8 multu 0xFF*0xFF -> busy 8 cycles, HI=0xFE LO=0x01.
